// File: rtl/video_capture_pkg.sv
// rtl/video_capture_pkg.sv - shared types and framebuffer geometry for video frame capture
package video_capture_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        FLUSH
    } state_t;

    localparam int FB_WIDTH  = 256;
    localparam int FB_HEIGHT = 240;
    localparam int FB_ADDR_W = 16;
    localparam int FB_DATA_W = 24;
    localparam int FIFO_W    = FB_ADDR_W + FB_DATA_W;

endpackage

// File: rtl/pixel_fifo.sv
// rtl/pixel_fifo.sv - first-word fall-through pixel FIFO with wrap-bit pointers
module pixel_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Pointer update; the extra MSB tells full from empty when the indices match.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (pop) begin
                rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Storage write; contents need no reset since empty masks them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/video_frame_capture.sv
// rtl/video_frame_capture.sv - PPU pixel stream to framebuffer writer; option VIDEO_CAPTURE_DROP_COUNT_EN
module video_frame_capture
    import video_capture_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_pixel_en,
    input  logic [7:0]           i_video_red,
    input  logic [7:0]           i_video_green,
    input  logic [7:0]           i_video_blue,
    input  logic [8:0]           i_video_x,
    input  logic [8:0]           i_video_y,
    input  logic                 i_video_visible,
    input  logic                 i_enable,
    output logic                 o_fb_valid,
    input  logic                 i_fb_ready,
    output logic [FB_ADDR_W-1:0] o_fb_address,
    output logic [FB_DATA_W-1:0] o_fb_data,
    output logic                 o_frame_start,
    output logic                 o_frame_done,
    output logic                 o_busy,
    output logic                 o_overflow,
    input  logic                 i_clear_overflow
`ifdef VIDEO_CAPTURE_DROP_COUNT_EN
    ,
    output logic [15:0]          o_drop_count
`endif
);

    state_t            state;
    state_t            state_next;
    logic              pix_ok;
    logic              is_first;
    logic              is_last;
    logic              push_req;
    logic              start_req;
    logic              push;
    logic              pop;
    logic              drop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FIFO_W-1:0] push_data;
    logic [FIFO_W-1:0] head_data;

    assign pix_ok   = i_pixel_en && i_video_visible &&
                      (i_video_x < 9'(FB_WIDTH)) && (i_video_y < 9'(FB_HEIGHT));
    assign is_first = pix_ok && (i_video_x == 9'd0) && (i_video_y == 9'd0);
    assign is_last  = pix_ok && (i_video_x == 9'(FB_WIDTH - 1)) &&
                      (i_video_y == 9'(FB_HEIGHT - 1));

    assign push_data = {i_video_y[7:0], i_video_x[7:0], i_video_red, i_video_green, i_video_blue};

    // A push only lands when there is room, counting a slot freed by a same-cycle pop.
    assign pop  = o_fb_valid && i_fb_ready;
    assign push = push_req && (!fifo_full || pop);
    assign drop = push_req && fifo_full && !pop;

    pixel_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (i_clk),
        .rst       (i_reset),
        .push      (push),
        .push_data (push_data),
        .full      (fifo_full),
        .pop       (pop),
        .head_data (head_data),
        .empty     (fifo_empty)
    );

    // Head of the FIFO is presented directly; zeroed while empty so idle outputs read 0.
    assign o_fb_valid   = !fifo_empty;
    assign o_fb_address = fifo_empty ? '0 : head_data[FIFO_W-1:FB_DATA_W];
    assign o_fb_data    = fifo_empty ? '0 : head_data[FB_DATA_W-1:0];
    assign o_busy       = (state != IDLE);

    // State register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, push request and frame pulse decode.
    always_comb begin
        state_next   = state;
        push_req     = 1'b0;
        start_req    = 1'b0;
        o_frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (is_first && i_enable) begin
                    start_req  = 1'b1;
                    push_req   = 1'b1;
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                push_req = pix_ok;
                if (is_first) begin
                    start_req = 1'b1;
                end
                if (is_last) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                if (fifo_empty) begin
                    o_frame_done = 1'b1;
                    state_next   = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Frame-start pulse is registered so it is a clean single cycle.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_frame_start <= 1'b0;
        end else begin
            o_frame_start <= start_req;
        end
    end

    // Sticky overflow flag; a new drop beats a simultaneous clear.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_overflow <= 1'b0;
        end else if (drop) begin
            o_overflow <= 1'b1;
        end else if (i_clear_overflow) begin
            o_overflow <= 1'b0;
        end
    end

`ifdef VIDEO_CAPTURE_DROP_COUNT_EN
    // Saturating dropped-pixel counter; an increment beats a simultaneous clear.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_drop_count <= '0;
        end else if (drop) begin
            if (o_drop_count != 16'hFFFF) begin
                o_drop_count <= o_drop_count + 16'd1;
            end
        end else if (i_clear_overflow) begin
            o_drop_count <= '0;
        end
    end
`endif

endmodule
